// File: rtl/bit_timer_seq_pkg.sv
// Shared definitions for the UART bit-period sequencer and the TX/RX engines.
package bit_timer_seq_pkg;

  localparam int CNT_W_DEF   = 19;
  localparam int BIT_W_DEF   = 4;
  localparam int MIN_PER_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HALF = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/bit_timer_seq_period_counter.sv
// Free-running cycle counter that flags the last cycle of a target period.
// hit is combinational from the count; count returns to 0 on hit or clear.
module bit_timer_seq_period_counter #(
  parameter int CNT_W = 19
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] target_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] count_q;

  assign hit_o = (count_q == target_i - CNT_W'(1));

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else if (clear_i || (en_i && hit_o)) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bit_timer_seq.sv
// Bit-period sequencer: registered btu tick every Pe cycles (optional Pe>>1 first tick),
// per-frame tick count with done on the Nth tick; N==0 free-runs until abort.
module bit_timer_seq
  import bit_timer_seq_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BIT_W   = BIT_W_DEF,
  parameter int MIN_PER = MIN_PER_DEF
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             half_first_i,
  input  logic [CNT_W-1:0] bit_period_i,
  input  logic [BIT_W-1:0] num_bits_i,
  output logic             btu_o,
  output logic [BIT_W-1:0] bit_idx_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q;
  logic [CNT_W-1:0] pe_q;
  logic [BIT_W-1:0] n_q;
  logic [BIT_W-1:0] bit_idx_q;
  logic             btu_q;
  logic             busy_q;
  logic             done_q;

  logic [CNT_W-1:0] pe_in;
  logic [CNT_W-1:0] target_d;
  logic [BIT_W-1:0] n_sel;
  logic [BIT_W-1:0] idx_d;
  logic             accept;
  logic             hit;
  logic             tick;
  logic             last;
  logic             cnt_clear;

  assign pe_in  = (bit_period_i < CNT_W'(MIN_PER)) ? CNT_W'(MIN_PER) : bit_period_i;
  // busy_q is still high in the done cycle, which blocks an immediate restart there
  assign accept = (state_q == ST_IDLE) && !busy_q && start_i && !abort_i;

  // The counter already runs in the start cycle, so it must see the live request
  always_comb begin
    target_d = pe_q;
    case (state_q)
      ST_IDLE: target_d = half_first_i ? (pe_in >> 1) : pe_in;
      ST_HALF: target_d = pe_q >> 1;
      default: target_d = pe_q;
    endcase
  end

  assign n_sel     = (state_q == ST_IDLE) ? num_bits_i : n_q;
  assign idx_d     = ((state_q == ST_IDLE) ? '0 : bit_idx_q) + BIT_W'(1);
  assign tick      = hit && !abort_i && (accept || (state_q != ST_IDLE));
  assign last      = tick && (n_sel != '0) && (idx_d == n_sel);
  assign cnt_clear = abort_i || ((state_q == ST_IDLE) && !accept);

  bit_timer_seq_period_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .clear_i  (cnt_clear),
    .en_i     (1'b1),
    .target_i (target_d),
    .hit_o    (hit)
  );

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      pe_q      <= '0;
      n_q       <= '0;
      bit_idx_q <= '0;
      btu_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      btu_q  <= tick;
      done_q <= last;
      if (tick) begin
        bit_idx_q <= idx_d;
      end else if (accept) begin
        bit_idx_q <= '0;
      end

      if (abort_i) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept) begin
              pe_q   <= pe_in;
              n_q    <= num_bits_i;
              busy_q <= 1'b1;
              if (last) begin
                state_q <= ST_IDLE;
              end else if (tick || !half_first_i) begin
                state_q <= ST_RUN;
              end else begin
                state_q <= ST_HALF;
              end
            end else begin
              busy_q <= 1'b0;
            end
          end
          ST_HALF: begin
            if (last) begin
              state_q <= ST_IDLE;
            end else if (tick) begin
              state_q <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (last) begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign btu_o     = btu_q;
  assign bit_idx_o = bit_idx_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_bit_timer_seq.sv
// Directed bench for bit_timer_seq: table of frame scenarios plus hand-coded corner sequences.
module tb_bit_timer_seq;

  localparam int CNT_W = 19;
  localparam int BIT_W = 4;

  logic             clk = 1'b0;
  logic             reset_ni;
  logic             start_i;
  logic             abort_i;
  logic             half_first_i;
  logic [CNT_W-1:0] bit_period_i;
  logic [BIT_W-1:0] num_bits_i;
  logic             btu_o;
  logic [BIT_W-1:0] bit_idx_o;
  logic             busy_o;
  logic             done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_timer_seq #(
    .CNT_W   (CNT_W),
    .BIT_W   (BIT_W),
    .MIN_PER (2)
  ) dut (
    .clock_i      (clk),
    .reset_ni     (reset_ni),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .half_first_i (half_first_i),
    .bit_period_i (bit_period_i),
    .num_bits_i   (num_bits_i),
    .btu_o        (btu_o),
    .bit_idx_o    (bit_idx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  // per: requested period, pe/first: hand-computed effective period and first tick cycle
  typedef struct {
    int per;
    int nb;
    bit half;
    int abort_at;
    int pe;
    int first;
    int len;
  } scen_t;

  task automatic chk(input string name, input int c, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int c, input int e_btu, input int e_done,
                         input int e_busy, input int e_idx, input bit do_idx);
    chk({tag, ".btu"}, c, int'(btu_o), e_btu);
    chk({tag, ".done"}, c, int'(done_o), e_done);
    chk({tag, ".busy"}, c, int'(busy_o), e_busy);
    if (do_idx) chk({tag, ".idx"}, c, int'(bit_idx_o), e_idx);
  endtask

  // Ticks visible by cycle c: first + k*pe, capped by N and by the abort cycle
  function automatic int exp_idx(input scen_t s, input int c);
    int n;
    int lim;
    n = (c < s.first) ? 0 : (c - s.first) / s.pe + 1;
    if (s.nb != 0 && n > s.nb) n = s.nb;
    if (s.abort_at >= 0) begin
      lim = (s.abort_at < s.first) ? 0 : (s.abort_at - s.first) / s.pe + 1;
      if (n > lim) n = lim;
    end
    return n;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    scen_t tbl[6];
    logic [15:0] m5_btu;
    logic [15:0] m5_done;
    logic [15:0] m5_busy;
    int          e5_idx[11];
    logic [31:0] m6_btu;
    logic [31:0] m6_busy;
    int          endt;
    int          ei;
    int          eb;

    tbl[0] = '{per: 10, nb: 10, half: 1'b0, abort_at: -1, pe: 10, first: 10, len: 103};
    tbl[1] = '{per: 10, nb: 3,  half: 1'b1, abort_at: -1, pe: 10, first: 5,  len: 28};
    tbl[2] = '{per: 4,  nb: 0,  half: 1'b0, abort_at: 21, pe: 4,  first: 4,  len: 26};
    tbl[3] = '{per: 3,  nb: 1,  half: 1'b1, abort_at: -1, pe: 3,  first: 1,  len: 4};
    tbl[4] = '{per: 1,  nb: 2,  half: 1'b1, abort_at: -1, pe: 2,  first: 1,  len: 6};
    tbl[5] = '{per: 7,  nb: 4,  half: 1'b0, abort_at: 14, pe: 7,  first: 7,  len: 24};

    reset_ni     = 1'b0;
    start_i      = 1'b1;
    abort_i      = 1'b0;
    half_first_i = 1'b0;
    bit_period_i = 19'd10;
    num_bits_i   = 4'd3;

    // Reset hold with start asserted: nothing may start
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      chk_out("reset_hold", i, 0, 0, 0, 0, 1'b1);
    end
    reset_ni = 1'b1;
    start_i  = 1'b0;
    next_cycle();
    next_cycle();

    // abort and start together in IDLE: abort wins
    start_i = 1'b1;
    abort_i = 1'b1;
    next_cycle();
    start_i = 1'b0;
    abort_i = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk_out("abort_start", i, 0, 0, 0, 0, 1'b1);
      next_cycle();
    end

    foreach (tbl[k]) begin
      bit_period_i = CNT_W'(tbl[k].per);
      num_bits_i   = BIT_W'(tbl[k].nb);
      half_first_i = tbl[k].half;
      endt = (tbl[k].nb != 0) ? tbl[k].first + (tbl[k].nb - 1) * tbl[k].pe : 1000000;
      if (tbl[k].abort_at >= 0 && tbl[k].abort_at < endt) endt = tbl[k].abort_at;
      for (int c = 0; c <= tbl[k].len; c++) begin
        next_cycle();
        start_i = (c == 0);
        abort_i = (c == tbl[k].abort_at);
        @(negedge clk);
        ei = exp_idx(tbl[k], c);
        eb = (c >= 1 && ei != exp_idx(tbl[k], c - 1)) ? 1 : 0;
        chk_out($sformatf("scen%0d", k), c, eb,
                (eb == 1 && tbl[k].nb != 0 && ei == tbl[k].nb) ? 1 : 0,
                (c >= 1 && c <= endt) ? 1 : 0, ei % 16, c >= 1);
      end
      start_i = 1'b0;
      abort_i = 1'b0;
    end

    // P=0 clamps to 2; restart in the done cycle is ignored, one cycle later it is taken
    m5_btu  = 16'h0294;
    m5_done = 16'h0210;
    m5_busy = 16'h03DE;
    e5_idx  = '{0, 0, 1, 1, 2, 2, 0, 1, 1, 2, 2};
    bit_period_i = '0;
    num_bits_i   = 4'd2;
    half_first_i = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      next_cycle();
      start_i = (c == 0 || c == 4 || c == 5);
      @(negedge clk);
      chk_out("clamp_restart", c, int'(m5_btu[c]), int'(m5_done[c]), int'(m5_busy[c]),
              e5_idx[c], c >= 1);
    end
    start_i = 1'b0;

    // Mid-frame period change is ignored; reset at cycle 15 clears everything
    m6_btu  = 32'h0000_0400;
    m6_busy = 32'h0000_FFFE;
    bit_period_i = 19'd10;
    num_bits_i   = 4'd5;
    for (int c = 0; c <= 16; c++) begin
      next_cycle();
      start_i  = (c == 0);
      reset_ni = (c != 15);
      if (c == 12) bit_period_i = 19'd3;
      @(negedge clk);
      chk_out("midframe_reset", c, int'(m6_btu[c]), 0, int'(m6_busy[c]),
              (c >= 10 && c <= 15) ? 1 : 0, c >= 1);
    end
    reset_ni = 1'b1;
    start_i  = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
